// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl -- instruction sequencer for the BNN core.
//
// Fetches 16-bit instructions from the instruction SRAM using its own PC.
// Scalar ops (load-imm, add, compare, branch) run locally in two cycles
// (FETCH + EXEC). LOAD, STORE and CORE instructions are forwarded to the
// core over a valid/ready handshake. LOAD and STORE then spend one MEM cycle
// strobing the data SRAM and post-increment their pointer register.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, start_pc       1-cycle launch pulse (IDLE only) and first address
//   abort                 synchronous abort, back to IDLE without done
//   inst_addr/re/rdata    instruction SRAM port (rdata valid one cycle after re)
//   data_addr/re/we       data SRAM strobes, one cycle each
//   core_cmd_valid/ready  command handshake, core_cmd is the raw instruction
//   busy, done            status: busy outside IDLE, done pulses after HALT
module bnn_seq_ctrl #(
  parameter int INST_W = 16,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              abort,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_re,
  input  logic [INST_W-1:0] inst_rdata,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_re,
  output logic              data_we,
  output logic              core_cmd_valid,
  output logic [INST_W-1:0] core_cmd,
  input  logic              core_cmd_ready,
  output logic              busy,
  output logic              done
);

  localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [4:0] OP_LDL   = 5'b00001;
  localparam logic [4:0] OP_LDH   = 5'b00010;
  localparam logic [4:0] OP_ADDI  = 5'b00011;
  localparam logic [4:0] OP_CMP   = 5'b00100;
  localparam logic [4:0] OP_BRB   = 5'b00101;
  localparam logic [4:0] OP_LOAD  = 5'b00110;
  localparam logic [4:0] OP_STORE = 5'b00111;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1'b1);
  localparam logic [DATA_W-1:0] REG_ONE  = DATA_W'(1'b1);
  localparam logic [DATA_W-1:0] REG_ZERO = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_ISSUE = 3'd3,
    S_MEM   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic                flag_q, flag_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
  logic                inst_re_q, inst_re_d;
  logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
  logic                data_re_q, data_re_d;
  logic                data_we_q, data_we_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Fields of the word arriving from SRAM (EXEC) and of the latched one (ISSUE/MEM).
  logic [4:0]          op_in, op_ir;
  logic [RIDX_W-1:0]   rd_in, rd_ir;
  logic [7:0]          imm_in;
  logic [DATA_W-1:0]   rval_in;

  assign op_in   = inst_rdata[INST_W-1 -: 5];
  assign rd_in   = inst_rdata[8 +: RIDX_W];
  assign imm_in  = inst_rdata[7:0];
  assign rval_in = regs_q[rd_in];
  assign op_ir   = ir_q[INST_W-1 -: 5];
  assign rd_ir   = ir_q[8 +: RIDX_W];

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flag_d      = flag_q;
    regs_d      = regs_q;
    data_addr_d = data_addr_q;

    if (abort) begin
      // Abort wins over start and ready; architectural state is left intact.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_d    = start_pc;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          state_d = S_EXEC;
        end
        S_EXEC: begin
          ir_d    = inst_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH;
          casez (op_in)
            OP_LDL:  regs_d[rd_in][7:0]  = imm_in;
            OP_LDH:  regs_d[rd_in][15:8] = imm_in;
            OP_ADDI: regs_d[rd_in]       = rval_in + DATA_W'(imm_in);
            OP_CMP:  flag_d              = (rval_in < DATA_W'(imm_in));
            OP_BRB: begin
              // Backward branch; the subtraction wraps modulo the address space.
              if (flag_q) begin
                pc_d = pc_q - ADDR_W'(inst_rdata[10:0]);
              end else begin
                pc_d = pc_q + PC_ONE;
              end
            end
            OP_LOAD, OP_STORE, 5'b01???: begin
              // PC advances only once the core has taken the command.
              pc_d    = pc_q;
              state_d = S_ISSUE;
            end
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = S_DONE;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_ISSUE: begin
          if (core_cmd_ready) begin
            pc_d = pc_q + PC_ONE;
            if ((op_ir == OP_LOAD) || (op_ir == OP_STORE)) begin
              data_addr_d = regs_q[rd_ir][ADDR_W-1:0];
              state_d     = S_MEM;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_MEM: begin
          // Post-increment the pointer that was just presented on data_addr.
          regs_d[rd_ir] = regs_q[rd_ir] + REG_ONE;
          state_d       = S_FETCH;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    regs_d[0] = REG_ZERO;

    // Outputs are a function of the state being entered, so they line up with it.
    inst_re_d   = (state_d == S_FETCH);
    inst_addr_d = (state_d == S_FETCH) ? pc_d : inst_addr_q;
    cmd_valid_d = (state_d == S_ISSUE);
    data_re_d   = (state_d == S_MEM) && (op_ir == OP_LOAD);
    data_we_d   = (state_d == S_MEM) && (op_ir == OP_STORE);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= {ADDR_W{1'b0}};
      ir_q        <= {INST_W{1'b0}};
      flag_q      <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= REG_ZERO;
      end
      inst_addr_q <= {ADDR_W{1'b0}};
      inst_re_q   <= 1'b0;
      data_addr_q <= {ADDR_W{1'b0}};
      data_re_q   <= 1'b0;
      data_we_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      flag_q      <= flag_d;
      regs_q      <= regs_d;
      inst_addr_q <= inst_addr_d;
      inst_re_q   <= inst_re_d;
      data_addr_q <= data_addr_d;
      data_re_q   <= data_re_d;
      data_we_q   <= data_we_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign inst_addr      = inst_addr_q;
  assign inst_re        = inst_re_q;
  assign data_addr      = data_addr_q;
  assign data_re        = data_re_q;
  assign data_we        = data_we_q;
  assign core_cmd_valid = cmd_valid_q;
  assign core_cmd       = ir_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Scoreboard bench for bnn_seq_ctrl: directed programs push their expected
// core handshakes, data strobes, fetches and done pulses into a queue; a
// monitor on the falling edge pops and compares whenever the DUT shows one.
module tb_bnn_seq_ctrl;
  localparam int AW = 13;
  localparam int IW = 16;

  localparam logic [2:0] K_CMD   = 3'd0;
  localparam logic [2:0] K_RD    = 3'd1;
  localparam logic [2:0] K_WR    = 3'd2;
  localparam logic [2:0] K_DONE  = 3'd3;
  localparam logic [2:0] K_FETCH = 3'd4;

  localparam logic [15:0] HALT_W = 16'hF800;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] inst_addr;
  logic          inst_re;
  logic [IW-1:0] inst_rdata = '0;
  logic [AW-1:0] data_addr;
  logic          data_re;
  logic          data_we;
  logic          core_cmd_valid;
  logic [IW-1:0] core_cmd;
  logic          core_cmd_ready = 1'b1;
  logic          busy;
  logic          done;

  logic [IW-1:0] imem [0:(1<<AW)-1];

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] val;
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit track_fetch = 1'b0;

  bnn_seq_ctrl #(.INST_W(IW), .ADDR_W(AW), .DATA_W(16), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .abort(abort),
    .inst_addr(inst_addr), .inst_re(inst_re), .inst_rdata(inst_rdata),
    .data_addr(data_addr), .data_re(data_re), .data_we(data_we),
    .core_cmd_valid(core_cmd_valid), .core_cmd(core_cmd), .core_cmd_ready(core_cmd_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous instruction SRAM: data appears the cycle after inst_re.
  always @(posedge clk) begin
    if (inst_re) inst_rdata <= imem[inst_addr];
  end

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [2:0] kind, input logic [15:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got kind %0d value 0x%0h, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("sb_event", {13'd0, kind, val}, {13'd0, e.kind, e.val});
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_cmd_valid && core_cmd_ready && !abort) observe(K_CMD, core_cmd);
      if (data_re) observe(K_RD, {3'd0, data_addr});
      if (data_we) observe(K_WR, {3'd0, data_addr});
      if (done) observe(K_DONE, 16'h0000);
      if (track_fetch && inst_re) observe(K_FETCH, {3'd0, inst_addr});
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) imem[i] = HALT_W;
  endtask

  task automatic pulse_start(input logic [AW-1:0] pc);
    start    = 1'b1;
    start_pc = pc;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst_re", {31'd0, inst_re}, 32'd0);
    check("rst_inst_addr", {19'd0, inst_addr}, 32'd0);
    check("rst_data_strobes", {30'd0, data_re, data_we}, 32'd0);
    check("rst_data_addr", {19'd0, data_addr}, 32'd0);
    check("rst_cmd", {15'd0, core_cmd_valid, core_cmd}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: build 0x1333 in r2 and use it as a LOAD pointer.
    imem[0] = ins(5'b00001, 3'd2, 8'h34);
    imem[1] = ins(5'b00010, 3'd2, 8'h12);
    imem[2] = ins(5'b00011, 3'd2, 8'hFF);
    imem[3] = ins(5'b00110, 3'd2, 8'h00);
    imem[4] = HALT_W;
    push(K_CMD, 16'h3200);
    push(K_RD, 16'h1333);
    push(K_DONE, 16'h0000);
    pulse_start(13'h0000);
    wait_idle(200, "t1");

    // 2: four-iteration loop; a stray start mid-run must be ignored.
    clear_mem();
    imem[0] = ins(5'b00001, 3'd3, 8'h00);
    imem[1] = 16'h4800;
    imem[2] = ins(5'b00011, 3'd3, 8'h01);
    imem[3] = ins(5'b00100, 3'd3, 8'h04);
    imem[4] = {5'b00101, 11'd3};
    imem[5] = HALT_W;
    for (int i = 0; i < 4; i++) push(K_CMD, 16'h4800);
    push(K_DONE, 16'h0000);
    pulse_start(13'h0000);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(13'h0100);
    check("t2_busy_after_stray_start", {31'd0, busy}, 32'd1);
    wait_idle(400, "t2");

    // 3: STORE held off by the core for five cycles.
    clear_mem();
    imem[13'h200] = ins(5'b00001, 3'd5, 8'h10);
    imem[13'h201] = ins(5'b00111, 3'd5, 8'h00);
    imem[13'h202] = HALT_W;
    push(K_CMD, 16'h3D00);
    push(K_WR, 16'h0010);
    push(K_DONE, 16'h0000);
    core_cmd_ready = 1'b0;
    pulse_start(13'h0200);
    n = 0;
    while (!core_cmd_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("t3_valid_held", {31'd0, core_cmd_valid}, 32'd1);
      check("t3_cmd_stable", {16'd0, core_cmd}, 32'h3D00);
      check("t3_no_fetch_no_we", {30'd0, inst_re, data_we}, 32'd0);
      @(posedge clk); #1;
    end
    core_cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_mem_we", {31'd0, data_we}, 32'd1);
    check("t3_mem_valid_low", {31'd0, core_cmd_valid}, 32'd0);
    @(posedge clk); #1;
    check("t3_refetch_addr", {18'd0, inst_re, inst_addr}, {18'd0, 1'b1, 13'h0202});
    wait_idle(200, "t3");

    // 4: pointer wraps from 0x1FFF to 0x0000 after post-increment.
    clear_mem();
    imem[13'h300] = ins(5'b00001, 3'd1, 8'hFF);
    imem[13'h301] = ins(5'b00010, 3'd1, 8'h1F);
    imem[13'h302] = ins(5'b00110, 3'd1, 8'h00);
    imem[13'h303] = ins(5'b00110, 3'd1, 8'h00);
    push(K_CMD, 16'h3100);
    push(K_RD, 16'h1FFF);
    push(K_CMD, 16'h3100);
    push(K_RD, 16'h0000);
    push(K_DONE, 16'h0000);
    pulse_start(13'h0300);
    wait_idle(200, "t4");

    // 5: taken branch from pc 2 by 3 wraps to 0x1FFF.
    clear_mem();
    imem[0] = 16'h0000;
    imem[1] = ins(5'b00100, 3'd0, 8'h01);
    imem[2] = {5'b00101, 11'd3};
    push(K_FETCH, 16'h0000);
    push(K_FETCH, 16'h0001);
    push(K_FETCH, 16'h0002);
    push(K_FETCH, 16'h1FFF);
    push(K_DONE, 16'h0000);
    track_fetch = 1'b1;
    pulse_start(13'h0000);
    wait_idle(200, "t5");
    track_fetch = 1'b0;

    // 6a: abort while a CORE command waits for ready.
    clear_mem();
    imem[13'h400] = 16'h4ABC;
    core_cmd_ready = 1'b0;
    pulse_start(13'h0400);
    n = 0;
    while (!core_cmd_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_valid_before_abort", {31'd0, core_cmd_valid}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t6_abort_valid", {31'd0, core_cmd_valid}, 32'd0);
    check("t6_abort_busy_done", {30'd0, busy, done}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    core_cmd_ready = 1'b1;
    check("t6_abort_stays_idle", {31'd0, busy}, 32'd0);
    check("t6_abort_queue_empty", exp_q.size(), 32'd0);

    // 6b: reset asserted during the MEM cycle drops the strobe at once.
    imem[13'h500] = ins(5'b00110, 3'd0, 8'h00);
    push(K_CMD, 16'h3000);
    pulse_start(13'h0500);
    n = 0;
    while (!data_re && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_mem_reached", {31'd0, data_re}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data_re", {31'd0, data_re}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 7: registers cleared by reset, so LOAD r2 now points at 0.
    imem[13'h600] = ins(5'b00110, 3'd2, 8'h00);
    push(K_CMD, 16'h3200);
    push(K_RD, 16'h0000);
    push(K_DONE, 16'h0000);
    pulse_start(13'h0600);
    wait_idle(200, "t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
